// File: rtl/otter_mem_arbiter_pkg.sv
// otter_pkg: shared types for the OTTER data-port arbiter.
// States, owner encoding and access-size codes.
package otter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: requester and memory bus bundle.
// slave = arbiter view, master = requesters/memory view.
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [1:0]        cpu_size;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [1:0]        dma_size;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  logic              mem_rden;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_rdata;

  logic              arb_busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr,
    input  cpu_wdata, cpu_size,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  dma_req, dma_we, dma_addr,
    input  dma_wdata, dma_size,
    output dma_rdata, dma_ack,
    output mem_rden, mem_we, mem_addr,
    output mem_wdata, mem_size,
    input  mem_rdata,
    output arb_busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr,
    output cpu_wdata, cpu_size,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output dma_req, dma_we, dma_addr,
    output dma_wdata, dma_size,
    input  dma_rdata, dma_ack,
    input  mem_rden, mem_we, mem_addr,
    input  mem_wdata, mem_size,
    output mem_rdata,
    input  arb_busy
  );

endinterface

// File: rtl/otter_mem_arbiter_sel.sv
// otter_arb_sel: combinational grant select.
// MEM_ARB_RR_EN selects round-robin, else CPU-first priority.
module otter_arb_sel
  import otter_pkg::*;
(
  input  logic   cpu_req,
  input  logic   dma_req,
  input  owner_t last_grant,
  output owner_t grant
);

  // Pick the next owner; result is unused when nobody requests.
  always_comb begin
    grant = last_grant;
`ifdef MEM_ARB_RR_EN
    if (cpu_req && dma_req)
      grant = (last_grant == OWN_CPU) ?
              OWN_DMA : OWN_CPU;
    else if (cpu_req)
      grant = OWN_CPU;
    else if (dma_req)
      grant = OWN_DMA;
`else
    if (cpu_req)
      grant = OWN_CPU;
    else if (dma_req)
      grant = OWN_DMA;
`endif
  end

endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares OTTER memory port 2 between CPU and DMA.
// MEM_ARB_RR_EN enables round-robin grant on ties.
module otter_mem_arbiter
  import otter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic                 CLK,
  input logic                 RST,
  otter_mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  arb_state_t        state;
  owner_t            owner;
  owner_t            last_grant;
  owner_t            grant;
  logic              lat_we;
  logic [3:0]        lat_cnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;

  logic              cpu_ack_q;
  logic              dma_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              mem_rden_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        mem_size_q;

  otter_arb_sel u_sel (
    .cpu_req    (bus.cpu_req),
    .dma_req    (bus.dma_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Route the granted requester's fields to the latch inputs.
  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_size  = bus.cpu_size;
    if (grant == OWN_DMA) begin
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
      sel_size  = bus.dma_size;
    end
  end

  // Access FSM; strobes and acks are registered one-cycle pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      owner       <= OWN_CPU;
      last_grant  <= OWN_DMA;
      lat_we      <= 1'b0;
      lat_cnt     <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      mem_rden_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
    end else begin
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      mem_rden_q <= 1'b0;
      mem_we_q   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            owner       <= grant;
            last_grant  <= grant;
            lat_we      <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_size_q  <= sel_size;
            mem_we_q    <= sel_we;
            mem_rden_q  <= ~sel_we;
            if (sel_we) begin
              cpu_ack_q <= (grant == OWN_CPU);
              dma_ack_q <= (grant == OWN_DMA);
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lat_we) begin
            state <= ST_IDLE;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (owner == OWN_CPU) begin
              cpu_rdata_q <= bus.mem_rdata;
              cpu_ack_q   <= 1'b1;
            end else begin
              dma_rdata_q <= bus.mem_rdata;
              dma_ack_q   <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.mem_rden  = mem_rden_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;
  assign bus.arb_busy  = (state != ST_IDLE);

endmodule
